// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Channel state, configuration record and default-divisor computation.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } ch_state_t;

    // Divisor is carried at full 32 bits; only the low DIV_W bits are ever set.
    typedef struct packed {
        logic [31:0] div;
        logic        oneshot;
    } ch_cfg_t;

    function automatic int calc_div(input int clk_hz, input int out_hz);
        return clk_hz / out_hz;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: run/halt FSM, period counter, divisor shadow and
// registered tick / square / busy outputs.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEF_DIV     = 100,
    parameter bit DEF_ONESHOT = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             restart_i,
    input  logic             we_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             oneshot_i,
    output logic             tick_o,
    output logic             clk_o,
    output logic             busy_o
);

    ch_state_t        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    ch_cfg_t          act_q, act_d;
    ch_cfg_t          sh_q, sh_d;
    ch_cfg_t          wr_cfg, def_cfg;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;
    logic             busy_q;
    logic             wrap;
    logic             bnd;

    assign wr_cfg  = '{div: 32'(div_i), oneshot: oneshot_i};
    assign def_cfg = '{div: 32'(DEF_DIV), oneshot: DEF_ONESHOT};

    assign wrap = (state_q == RUN) && (32'(cnt_q) == act_q.div - 32'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        bnd     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (!en_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (restart_i) begin
                    cnt_d = '0;
                    bnd   = 1'b1;
                end else if (wrap) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    bnd    = 1'b1;
                    if (act_q.oneshot) begin
                        state_d = HALT;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            HALT: begin
                cnt_d = '0;
                if (!en_i) begin
                    state_d = IDLE;
                end else if (restart_i) begin
                    state_d = RUN;
                    bnd     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A write landing on a period boundary bypasses the shadow entirely.
    always_comb begin
        act_d  = act_q;
        sh_d   = we_i ? wr_cfg : sh_q;
        pend_d = pend_q | we_i;
        if (bnd && we_i) begin
            act_d  = wr_cfg;
            pend_d = 1'b0;
        end else if ((bnd || state_q != RUN) && pend_q) begin
            act_d  = sh_q;
            pend_d = we_i;
        end
        clk_d = (state_d == RUN) &&
                (32'(cnt_d) < ((act_d.div + 32'd1) >> 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            act_q   <= def_cfg;
            sh_q    <= def_cfg;
            pend_q  <= 1'b0;
            tick_q  <= 1'b0;
            clk_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            sh_q    <= sh_d;
            pend_q  <= pend_d;
            tick_q  <= tick_d;
            clk_q   <= clk_d;
            busy_q  <= (state_d == RUN);
        end
    end

    assign tick_o = tick_q;
    assign clk_o  = clk_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/multi_clock_divider.sv
// N-channel programmable tick / square-wave divider with glitch-free
// divisor updates and a common phase-aligning restart.
module multi_clock_divider
    import clk_div_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int DIV_W       = 16,
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int DEF_FREQ_HZ = 1_000_000,
    parameter bit DEF_ONESHOT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       en,
    input  logic                  sync_restart,
    input  logic                  cfg_we,
    input  logic [$clog2(N_CH):0] cfg_ch,
    input  logic [DIV_W-1:0]      cfg_div,
    input  logic                  cfg_oneshot,
    output logic                  cfg_err,
    output logic [N_CH-1:0]       tick_out,
    output logic [N_CH-1:0]       clk_out,
    output logic [N_CH-1:0]       busy
);

    localparam int DEF_DIV = calc_div(CLK_FREQ_HZ, DEF_FREQ_HZ);

    logic            ch_ok;
    logic            cfg_ok;
    logic            cfg_err_q, cfg_err_d;
    logic [N_CH-1:0] ch_we;

    assign ch_ok     = 32'(cfg_ch) < 32'(N_CH);
    assign cfg_ok    = cfg_we && (cfg_div != '0) && ch_ok;
    assign cfg_err_d = cfg_we && !cfg_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign ch_we[g] = cfg_ok && (32'(cfg_ch) == g);

        clk_div_channel #(
            .DIV_W       (DIV_W),
            .DEF_DIV     (DEF_DIV),
            .DEF_ONESHOT (DEF_ONESHOT)
        ) u_ch (
            .clk_i     (clk),
            .rst_i     (rst),
            .en_i      (en[g]),
            .restart_i (sync_restart),
            .we_i      (ch_we[g]),
            .div_i     (cfg_div),
            .oneshot_i (cfg_oneshot),
            .tick_o    (tick_out[g]),
            .clk_o     (clk_out[g]),
            .busy_o    (busy[g])
        );
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Self-checking bench for multi_clock_divider: directed corner sequences,
// a config-error vector table and randomized traffic against a reference model.
module tb_multi_clock_divider;

    localparam int N       = 4;
    localparam int DW      = 16;
    localparam int DEF_DIV = 100_000_000 / 1_000_000;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_HALT  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  en = 4'b0001;
    logic          sync_restart = 1'b0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_ch = '0;
    logic [DW-1:0] cfg_div = '0;
    logic          cfg_oneshot = 1'b0;
    logic          cfg_err;
    logic [N-1:0]  tick_out;
    logic [N-1:0]  clk_out;
    logic [N-1:0]  busy;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    always #5 clk = ~clk;

    multi_clock_divider dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sync_restart (sync_restart),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .cfg_oneshot  (cfg_oneshot),
        .cfg_err      (cfg_err),
        .tick_out     (tick_out),
        .clk_out      (clk_out),
        .busy         (busy)
    );

    // Reference model: age = edges elapsed in the current period.
    int           m_st[N];
    int           m_age[N];
    int           m_div[N];
    bit           m_one[N];
    int           m_sdiv[N];
    bit           m_sone[N];
    bit           m_pend[N];
    logic [N-1:0] m_tick = '0;
    logic [N-1:0] m_clk = '0;
    logic [N-1:0] m_busy = '0;
    logic         m_err = 1'b0;

    task automatic model_step();
        bit bad;
        bit hit;
        bit bnd;
        int ost;
        bad = cfg_we && (cfg_div == 0 || int'(cfg_ch) >= N);
        if (rst) begin
            m_err = 1'b0;
            for (int c = 0; c < N; c++) begin
                m_st[c] = S_IDLE;  m_age[c] = 0;
                m_div[c] = DEF_DIV; m_one[c] = 1'b0;
                m_sdiv[c] = DEF_DIV; m_sone[c] = 1'b0;
                m_pend[c] = 1'b0;
                m_tick[c] = 1'b0; m_clk[c] = 1'b0; m_busy[c] = 1'b0;
            end
        end else begin
            m_err = bad;
            for (int c = 0; c < N; c++) begin
                hit = cfg_we && !bad && (int'(cfg_ch) == c);
                ost = m_st[c];
                bnd = 1'b0;
                m_tick[c] = 1'b0;
                if (!en[c]) begin
                    m_st[c] = S_IDLE; m_age[c] = 0;
                end else if (ost == S_IDLE) begin
                    m_st[c] = S_RUN; m_age[c] = 0;
                end else if (sync_restart) begin
                    m_st[c] = S_RUN; m_age[c] = 0; bnd = 1'b1;
                end else if (ost == S_RUN) begin
                    m_age[c]++;
                    if (m_age[c] == m_div[c]) begin
                        m_age[c] = 0; m_tick[c] = 1'b1; bnd = 1'b1;
                        if (m_one[c]) m_st[c] = S_HALT;
                    end
                end
                if (bnd && hit) begin
                    m_div[c] = int'(cfg_div); m_one[c] = cfg_oneshot;
                    m_pend[c] = 1'b0;
                end else if ((bnd || ost != S_RUN) && m_pend[c]) begin
                    m_div[c] = m_sdiv[c]; m_one[c] = m_sone[c];
                    m_pend[c] = hit;
                end else if (hit) begin
                    m_pend[c] = 1'b1;
                end
                if (hit) begin
                    m_sdiv[c] = int'(cfg_div); m_sone[c] = cfg_oneshot;
                end
                m_clk[c]  = (m_st[c] == S_RUN) && (m_age[c] < (m_div[c] + 1) / 2);
                m_busy[c] = (m_st[c] == S_RUN);
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            if ({tick_out, clk_out, busy, cfg_err} !== {m_tick, m_clk, m_busy, m_err}) begin
                errors++;
                $display("FAIL model t=%0t got tick=%b clk=%b busy=%b err=%b want tick=%b clk=%b busy=%b err=%b",
                         $time, tick_out, clk_out, busy, cfg_err, m_tick, m_clk, m_busy, m_err);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cfg(input int ch, input int div, input bit one);
        cfg_we = 1'b1;
        cfg_ch = 3'(ch);
        cfg_div = DW'(div);
        cfg_oneshot = one;
        step(1);
        cfg_we = 1'b0;
    endtask

    typedef struct {
        int ch;
        int div;
        bit we;
        bit exp_err;
    } err_vec_t;

    err_vec_t vt[7];

    initial begin
        int bt, bc, bo, nt, w, per, r0;

        vt[0] = '{0, 0, 1'b1, 1'b1};
        vt[1] = '{4, 7, 1'b1, 1'b1};
        vt[2] = '{7, 3, 1'b1, 1'b1};
        vt[3] = '{1, 0, 1'b1, 1'b1};
        vt[4] = '{3, 9, 1'b0, 1'b0};
        vt[5] = '{3, 9, 1'b1, 1'b0};
        vt[6] = '{2, 0, 1'b0, 1'b0};

        // Reset defaults
        step(2);
        rst = 1'b0;
        check("rst_tick", int'(tick_out), 0);
        check("rst_clk", int'(clk_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(cfg_err), 0);
        mon_on = 1'b1;
        bt = 0; bc = 0; bo = 0; nt = 0;
        for (int e = 0; e <= 300; e++) begin
            step(1);
            if (tick_out[0] != (e > 0 && e % 100 == 0)) bt++;
            if (clk_out[0] != ((e % 100) < 50)) bc++;
            if ({tick_out[3:1], clk_out[3:1], busy[3:1]} != '0) bo++;
            nt += int'(tick_out[0]);
        end
        check("def_tick_bad", bt, 0);
        check("def_clk_bad", bc, 0);
        check("def_other_bad", bo, 0);
        check("def_tick_cnt", nt, 3);

        // Divide by 3 on ch1
        cfg(1, 3, 1'b0);
        step(2);
        en[1] = 1'b1;
        bt = 0; bc = 0; nt = 0;
        for (int e = 0; e < 12; e++) begin
            step(1);
            if (tick_out[1] != (e > 0 && e % 3 == 0)) bt++;
            if (clk_out[1] != ((e % 3) < 2)) bc++;
            nt += int'(tick_out[1]);
        end
        check("div3_tick_bad", bt, 0);
        check("div3_clk_bad", bc, 0);
        check("div3_tick_cnt", nt, 3);

        // Mid-period divisor change on ch0
        en[0] = 1'b0;
        step(1);
        cfg(0, 10, 1'b0);
        step(2);
        en[0] = 1'b1;
        bt = 0; bc = 0; nt = 0;
        for (int e = 0; e <= 22; e++) begin
            step(1);
            if (e < 10) begin
                if (tick_out[0] != 1'b0) bt++;
                if (clk_out[0] != (e < 5)) bc++;
            end else begin
                if (tick_out[0] != ((e - 10) % 4 == 0)) bt++;
                if (clk_out[0] != (((e - 10) % 4) < 2)) bc++;
            end
            nt += int'(tick_out[0]);
            cfg_we = 1'b0;
            if (e == 5) begin
                cfg_we = 1'b1; cfg_ch = 3'd0; cfg_div = DW'(4); cfg_oneshot = 1'b0;
            end
        end
        check("chg_tick_bad", bt, 0);
        check("chg_clk_bad", bc, 0);
        check("chg_tick_cnt", nt, 4);

        // Oneshot on ch2, then re-arm with restart
        cfg(2, 5, 1'b1);
        step(2);
        en[2] = 1'b1;
        bt = 0; bo = 0; nt = 0;
        for (int e = 0; e <= 12; e++) begin
            step(1);
            if (tick_out[2] != (e == 5)) bt++;
            if (busy[2] != (e < 5)) bo++;
            nt += int'(tick_out[2]);
        end
        check("os_tick_bad", bt, 0);
        check("os_busy_bad", bo, 0);
        check("os_tick_cnt", nt, 1);
        sync_restart = 1'b1;
        step(1);
        sync_restart = 1'b0;
        bt = 0; nt = 0;
        for (int r = 0; r <= 10; r++) begin
            if (r > 0) step(1);
            if (tick_out[2] != (r == 5)) bt++;
            nt += int'(tick_out[2]);
        end
        check("os_rearm_bad", bt, 0);
        check("os_rearm_cnt", nt, 1);

        // Config error vectors
        foreach (vt[i]) begin
            cfg_we = vt[i].we;
            cfg_ch = 3'(vt[i].ch);
            cfg_div = DW'(vt[i].div);
            cfg_oneshot = 1'b0;
            step(1);
            cfg_we = 1'b0;
            check($sformatf("err_v%0d", i), int'(cfg_err), int'(vt[i].exp_err));
            step(1);
            check($sformatf("err_clr_v%0d", i), int'(cfg_err), 0);
        end
        w = 0;
        while (!tick_out[1] && w < 20) begin
            step(1);
            w++;
        end
        check("ch1_tick_seen", int'(w < 20), 1);
        per = 0;
        do begin
            step(1);
            per++;
        end while (!tick_out[1] && per < 20);
        check("ch1_period", per, 3);

        // Restart alignment, then reset mid-run
        en = '0;
        step(1);
        cfg(0, 7, 1'b0);
        cfg(1, 14, 1'b0);
        step(2);
        en = 4'b0011;
        step(5);
        sync_restart = 1'b1;
        step(1);
        sync_restart = 1'b0;
        bt = 0;
        for (int r = 1; r <= 14; r++) begin
            step(1);
            if (tick_out[0] != (r == 7 || r == 14)) bt++;
            if (tick_out[1] != (r == 14)) bt++;
        end
        check("rs_both_tick", int'(tick_out[1:0]), 3);
        check("rs_tick_bad", bt, 0);
        step(3);
        rst = 1'b1;
        step(1);
        check("rst_run_tick", int'(tick_out), 0);
        check("rst_run_clk", int'(clk_out), 0);
        check("rst_run_busy", int'(busy), 0);
        rst = 1'b0;

        // Randomized traffic checked by the model monitor
        r0 = 0;
        for (int k = 0; k < 3000; k++) begin
            cfg_we = 1'b0;
            sync_restart = 1'b0;
            rst = 1'b0;
            if ($urandom_range(0, 49) == 0) en = N'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                cfg_we = 1'b1;
                cfg_ch = 3'($urandom_range(0, 5));
                cfg_div = DW'($urandom_range(0, 12));
                cfg_oneshot = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 39) == 0) sync_restart = 1'b1;
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                r0++;
            end
            step(1);
        end
        cfg_we = 1'b0;
        sync_restart = 1'b0;
        rst = 1'b0;
        step(2);
        mon_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
